// File: rtl/fp16_round_norm_pipe_if.sv
// Stream interface for the fp16 normalise/round stage.
// The master drives the input beat and out_ready. The slave (the pipe) drives the result beat.
interface fp16_round_norm_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_mant_sum;
    logic [4:0]  in_exp_half;
    logic        in_sign_half;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    modport master (
        output in_valid, in_mant_sum, in_exp_half, in_sign_half, out_ready,
        input  in_ready, out_valid, q, out_ovf, out_unf, out_inexact
    );

    modport slave (
        input  in_valid, in_mant_sum, in_exp_half, in_sign_half, out_ready,
        output in_ready, out_valid, q, out_ovf, out_unf, out_inexact
    );
endinterface

// File: rtl/fp16_round_norm_pipe.sv
// Two-stage fp16 normalise (S1) and round/pack (S2) pipe placed after the mantissa adder.
// Both sides use a valid/ready handshake. A simultaneous pop and push keeps full throughput.
module fp16_round_norm_pipe #(
    parameter int ROUND_MODE = 0,
    parameter int FTZ        = 0
) (
    input logic clk,
    input logic rst_n,
    fp16_round_norm_pipe_if.slave bus
);
    logic        rdy_en;
    logic        s1_v, s1_sign, s1_zero;
    logic [13:0] s1_mant;
    logic [5:0]  s1_exp;
    logic        s2_v, s2_ovf, s2_unf, s2_inex;
    logic [15:0] s2_q;
    logic        s2_ready, in_ready;

    assign s2_ready        = !s2_v || bus.out_ready;
    assign in_ready        = rdy_en && (!s1_v || s2_ready);
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = s2_v;
    assign bus.q           = s2_q;
    assign bus.out_ovf     = s2_ovf;
    assign bus.out_unf     = s2_unf;
    assign bus.out_inexact = s2_inex;

    logic [14:0] mant;
    logic [5:0]  e_in, lz, sh, n_exp;
    logic [13:0] n_mant;
    logic        n_zero;

    assign mant = bus.in_mant_sum;

    always_comb begin
        e_in = (bus.in_exp_half == 5'd0) ? 6'd1 : {1'b0, bus.in_exp_half};
        lz   = 6'd14;
        for (int i = 0; i < 14; i++) begin
            if (mant[i]) lz = 6'(13 - i);
        end
        // The left shift stops at exponent 1, which leaves a subnormal result.
        sh     = (lz < e_in - 6'd1) ? lz : (e_in - 6'd1);
        n_mant = mant[13:0];
        n_exp  = e_in;
        n_zero = 1'b0;
        if (mant[14]) begin
            n_mant = {mant[14:2], mant[1] | mant[0]};
            n_exp  = e_in + 6'd1;
        end else if (!mant[13]) begin
            if (mant[13:0] != 14'd0) begin
                n_mant = mant[13:0] << sh;
                n_exp  = e_in - sh;
            end else begin
                n_zero = 1'b1;
            end
        end
    end

    logic        lsb, g, r, s_bit, inc;
    logic [11:0] sum;
    logic [5:0]  r_exp;
    logic [15:0] r_q;
    logic        r_ovf, r_unf, r_inex;

    always_comb begin
        lsb   = s1_mant[3];
        g     = s1_mant[2];
        r     = s1_mant[1];
        s_bit = s1_mant[0];
        inc   = (ROUND_MODE == 0) && g && (r || s_bit || lsb);
        sum   = {1'b0, s1_mant[13:3]} + {11'd0, inc};
        // A subnormal that rounds into the hidden bit becomes the smallest normal (exp 1).
        r_exp  = s1_mant[13] ? (s1_exp + {5'd0, sum[11]}) : {5'd0, sum[10]};
        r_q    = {s1_sign, r_exp[4:0], sum[9:0]};
        r_ovf  = 1'b0;
        r_unf  = 1'b0;
        r_inex = g || r || s_bit;
        if (s1_zero) begin
            r_q    = {s1_sign, 15'h0};
            r_inex = 1'b0;
        end else if (r_exp >= 6'd31) begin
            r_q    = {s1_sign, 5'h1F, 10'h0};
            r_ovf  = 1'b1;
            r_inex = 1'b1;
        end else if (r_exp == 6'd0) begin
            r_unf = 1'b1;
            if (FTZ != 0) r_q = {s1_sign, 15'h0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en  <= 1'b0;
            s1_v    <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_mant <= '0;
            s1_exp  <= '0;
            s2_v    <= 1'b0;
            s2_q    <= 16'h0000;
            s2_ovf  <= 1'b0;
            s2_unf  <= 1'b0;
            s2_inex <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (s2_ready) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_q    <= r_q;
                    s2_ovf  <= r_ovf;
                    s2_unf  <= r_unf;
                    s2_inex <= r_inex;
                end
            end
            if (in_ready) begin
                s1_v <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign <= bus.in_sign_half;
                    s1_zero <= n_zero;
                    s1_mant <= n_mant;
                    s1_exp  <= n_exp;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp16_round_norm_pipe.sv
// Bench for fp16_round_norm_pipe: RNE, RTZ and FTZ builds driven in lockstep.
// Results are checked against fixed vectors and against a value-based rounding model.
module tb_fp16_round_norm_pipe;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    fp16_round_norm_pipe_if bus_rne ();
    fp16_round_norm_pipe_if bus_rtz ();
    fp16_round_norm_pipe_if bus_ftz ();

    fp16_round_norm_pipe #(.ROUND_MODE(0), .FTZ(0)) u_rne (.clk(clk), .rst_n(rst_n), .bus(bus_rne));
    fp16_round_norm_pipe #(.ROUND_MODE(1), .FTZ(0)) u_rtz (.clk(clk), .rst_n(rst_n), .bus(bus_rtz));
    fp16_round_norm_pipe #(.ROUND_MODE(0), .FTZ(1)) u_ftz (.clk(clk), .rst_n(rst_n), .bus(bus_ftz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] mant;
        logic [4:0]  exp;
        logic        sign;
        logic [15:0] q_rne;
        logic [15:0] q_rtz;
        logic [15:0] q_ftz;
        logic [2:0]  fl;
    } vec_t;

    typedef struct packed {
        logic [14:0] m;
        logic [4:0]  e;
        logic        s;
    } beat_t;

    vec_t  vecs[10];
    beat_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact value in units of 2^-27, rounded to the fp16 grid of its binade.
    function automatic logic [18:0] model(input logic [14:0] mant, input logic [4:0] exp,
                                          input logic sign, input int rm, input int ftz);
        longint n, ulp, qm, rem, half;
        int     e, msb, pe, pexp;
        logic   inex, unf;
        logic [15:0] q;
        if (mant == 15'd0) return {3'b000, sign, 15'h0};
        e = (exp == 5'd0) ? 1 : int'(exp);
        n = longint'(mant) << (e - 1);
        msb = 0;
        for (int i = 0; i < 48; i++) if (n[i]) msb = i;
        pe = msb - 12;
        if (pe < 1) pe = 1;
        ulp  = longint'(1) << (pe + 2);
        qm   = n / ulp;
        rem  = n % ulp;
        half = ulp / 2;
        inex = (rem != 0);
        if (rm == 0 && (rem > half || (rem == half && qm[0]))) qm = qm + 1;
        if (qm >= 2048) begin
            qm = qm / 2;
            pe = pe + 1;
        end
        pexp = (qm < 1024) ? 0 : pe;
        if (pexp >= 31) return {3'b101, sign, 5'h1F, 10'h0};
        unf = (pexp == 0);
        q = {sign, 5'(pexp), qm[9:0]};
        if (unf && ftz != 0) q = {sign, 15'h0};
        return {1'b0, unf, inex, q};
    endfunction

    task automatic drive(input logic v, input logic [14:0] m, input logic [4:0] e,
                         input logic s, input logic r);
        bus_rne.in_valid = v; bus_rne.in_mant_sum = m; bus_rne.in_exp_half = e;
        bus_rne.in_sign_half = s; bus_rne.out_ready = r;
        bus_rtz.in_valid = v; bus_rtz.in_mant_sum = m; bus_rtz.in_exp_half = e;
        bus_rtz.in_sign_half = s; bus_rtz.out_ready = r;
        bus_ftz.in_valid = v; bus_ftz.in_mant_sum = m; bus_ftz.in_exp_half = e;
        bus_ftz.in_sign_half = s; bus_ftz.out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input beat_t b);
        logic [18:0] x_rne, x_rtz, x_ftz;
        x_rne = model(b.m, b.e, b.s, 0, 0);
        x_rtz = model(b.m, b.e, b.s, 1, 0);
        x_ftz = model(b.m, b.e, b.s, 0, 1);
        chk({tag, "_rne"}, 32'({bus_rne.out_ovf, bus_rne.out_unf, bus_rne.out_inexact, bus_rne.q}), 32'(x_rne));
        chk({tag, "_rtz"}, 32'({bus_rtz.out_ovf, bus_rtz.out_unf, bus_rtz.out_inexact, bus_rtz.q}), 32'(x_rtz));
        chk({tag, "_ftz"}, 32'({bus_ftz.out_ovf, bus_ftz.out_unf, bus_ftz.out_inexact, bus_ftz.q}), 32'(x_ftz));
    endtask

    initial begin
        int          sent, got, occ;
        logic        ordy, iv, was_stall;
        logic [15:0] held;
        logic [14:0] m;
        bit          pat[4];
        beat_t       b;

        vecs[0] = '{15'h4000, 5'd15, 1'b0, 16'h4000, 16'h4000, 16'h4000, 3'b000};
        vecs[1] = '{15'h2004, 5'd15, 1'b0, 16'h3C00, 16'h3C00, 16'h3C00, 3'b001};
        vecs[2] = '{15'h200C, 5'd15, 1'b0, 16'h3C02, 16'h3C01, 16'h3C02, 3'b001};
        vecs[3] = '{15'h3FFC, 5'd15, 1'b0, 16'h4000, 16'h3FFF, 16'h4000, 3'b001};
        vecs[4] = '{15'h7FFC, 5'd30, 1'b0, 16'h7C00, 16'h7C00, 16'h7C00, 3'b101};
        vecs[5] = '{15'h1000, 5'd15, 1'b0, 16'h3800, 16'h3800, 16'h3800, 3'b000};
        vecs[6] = '{15'h1000, 5'd1,  1'b0, 16'h0200, 16'h0200, 16'h0000, 3'b010};
        vecs[7] = '{15'h0000, 5'd15, 1'b1, 16'h8000, 16'h8000, 16'h8000, 3'b000};
        vecs[8] = '{15'h1FFC, 5'd1,  1'b0, 16'h0400, 16'h03FF, 16'h0400, 3'b001};
        vecs[9] = '{15'h4000, 5'd15, 1'b1, 16'hC000, 16'hC000, 16'hC000, 3'b000};

        rst_n = 1'b0;
        drive(1'b0, 15'h0, 5'h0, 1'b0, 1'b1);
        #12;
        chk("rst_valid", 32'({bus_rne.out_valid, bus_rtz.out_valid, bus_ftz.out_valid}), 32'(0));
        chk("rst_q", 32'(bus_rne.q), 32'(0));
        chk("rst_flags", 32'({bus_rne.out_ovf, bus_rne.out_unf, bus_rne.out_inexact}), 32'(0));
        chk("rst_in_ready", 32'(bus_rne.in_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(bus_rne.in_ready), 32'(1));

        foreach (vecs[k]) begin
            drive(1'b1, vecs[k].mant, vecs[k].exp, vecs[k].sign, 1'b1);
            #1;
            chk("vec_in_ready", 32'(bus_rne.in_ready), 32'(1));
            step();
            drive(1'b0, 15'h0, 5'h0, 1'b0, 1'b1);
            #1;
            chk("vec_lat1_valid", 32'(bus_rne.out_valid), 32'(0));
            step();
            #1;
            chk("vec_lat2_valid", 32'(bus_rne.out_valid), 32'(1));
            chk("vec_q_rne", 32'(bus_rne.q), 32'(vecs[k].q_rne));
            chk("vec_q_rtz", 32'(bus_rtz.q), 32'(vecs[k].q_rtz));
            chk("vec_q_ftz", 32'(bus_ftz.q), 32'(vecs[k].q_ftz));
            chk("vec_flags", 32'({bus_rne.out_ovf, bus_rne.out_unf, bus_rne.out_inexact}), 32'(vecs[k].fl));
            chk("vec_ftz_unf", 32'(bus_ftz.out_unf), 32'(vecs[k].fl[1]));
            step();
        end

        // Backpressure: eight back-to-back beats, out_ready cycling 1,0,0,1.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        sent = 0;
        got = 0;
        was_stall = 1'b0;
        held = 16'h0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            ordy = pat[cyc % 4];
            drive(sent < 8, 15'(15'h2000 | (sent << 3)), 5'd15, 1'b0, ordy);
            #1;
            occ = sent - got;
            chk("bp_in_ready", 32'(bus_rne.in_ready), 32'((occ < 2) || ordy));
            if (was_stall) begin
                chk("bp_hold_valid", 32'(bus_rne.out_valid), 32'(1));
                chk("bp_hold_q", 32'(bus_rne.q), 32'(held));
            end
            if (bus_rne.out_valid && ordy) begin
                chk("bp_order", 32'(bus_rne.q), 32'(16'h3C00 + 16'(got)));
                got++;
            end
            was_stall = bus_rne.out_valid && !ordy;
            held = bus_rne.q;
            if (sent < 8 && bus_rne.in_ready) sent++;
            step();
        end
        chk("bp_count", 32'(got), 32'(8));

        // Random stream against the model with a FIFO scoreboard.
        drive(1'b0, 15'h0, 5'h0, 1'b0, 1'b1);
        step();
        step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iv = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: m = 15'($urandom);
                1: m = 15'($urandom_range(0, 255));
                2: m = {2'b01, 13'($urandom)};
                default: m = 15'(15'h7FF8 | $urandom_range(0, 7));
            endcase
            b = '{m, 5'($urandom_range(0, 31)), 1'($urandom)};
            drive(iv, b.m, b.e, b.s, ordy);
            #1;
            occ = sb.size();
            chk("rand_in_ready", 32'(bus_rne.in_ready), 32'((occ < 2) || ordy));
            if (bus_rne.out_valid && ordy) begin
                if (sb.size() == 0) begin
                    chk("rand_spurious_out", 32'(1), 32'(0));
                end else begin
                    chk("rand_valid_rtz_ftz", 32'({bus_rtz.out_valid, bus_ftz.out_valid}), 32'(3));
                    check_beat("rand", sb.pop_front());
                end
            end
            if (iv && bus_rne.in_ready) sb.push_back(b);
            step();
        end
        drive(1'b0, 15'h0, 5'h0, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
            #1;
            if (bus_rne.out_valid) check_beat("drain", sb.pop_front());
            step();
        end
        chk("drain_empty", 32'(sb.size()), 32'(0));

        // Reset with two beats in flight.
        drive(1'b1, 15'h4000, 5'd15, 1'b0, 1'b0);
        step();
        drive(1'b1, 15'h4000, 5'd16, 1'b0, 1'b0);
        step();
        drive(1'b0, 15'h0, 5'h0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_valid", 32'(bus_rne.out_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'({bus_rne.out_valid, bus_rtz.out_valid, bus_ftz.out_valid}), 32'(0));
        chk("async_rst_q", 32'(bus_rne.q), 32'(0));
        chk("async_rst_in_ready", 32'(bus_rne.in_ready), 32'(0));
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, 15'h3FFC, 5'd15, 1'b0, 1'b1);
        #1;
        chk("rst2_in_ready", 32'(bus_rne.in_ready), 32'(1));
        step();
        drive(1'b0, 15'h0, 5'h0, 1'b0, 1'b1);
        #1;
        chk("rst2_lat1", 32'(bus_rne.out_valid), 32'(0));
        step();
        #1;
        chk("rst2_lat2", 32'(bus_rne.out_valid), 32'(1));
        chk("rst2_q", 32'(bus_rne.q), 32'(16'h4000));
        step();
        #1;
        chk("rst2_no_dup", 32'(bus_rne.out_valid), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
